// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
//   ALU_WIDTH    default operand/result width
//   ALU_*        4-bit operation codes produced by the ALU control decoder
//   alu_state_e  sequencing states (MUL/DONE only used with ALU_EXEC_MULT_EN)
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_MUL = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: operation/result handshake bundle of the execute-stage ALU.
//   in_valid/in_ready      operation transfer (ALUcontrole, a, b)
//   out_valid/out_ready    result transfer (resultado, zero, overflow)
//   master modport: upstream producer + downstream consumer side
//   slave modport:  the ALU itself
interface alu_exec_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUcontrole;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] resultado;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, ALUcontrole, a, b, out_ready,
        input  in_ready, out_valid, resultado, zero, overflow
    );

    modport slave (
        input  in_valid, ALUcontrole, a, b, out_ready,
        output in_ready, out_valid, resultado, zero, overflow
    );
endinterface

// File: rtl/alu_exec_mult_iter.sv
// mult_iter: iterative unsigned shift-add multiplier, one partial product per step.
//   start_i    latch a_i/b_i, clear accumulator and counter
//   step_i     perform one shift-add step
//   last_o     the next step is the final one (counter == WIDTH-1)
//   done_o     the final step is being taken this cycle
//   product_o  accumulator, low WIDTH bits of a*b once all steps are done
module mult_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] a_shift_q, a_shift_d;
    logic [WIDTH-1:0] b_shift_q, b_shift_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign last_o    = (cnt_q == CNT_W'(WIDTH - 1));
    assign done_o    = step_i && last_o;
    assign product_o = acc_q;

    // Next-state of the operand shifters, accumulator and step counter.
    always_comb begin
        a_shift_d = a_shift_q;
        b_shift_d = b_shift_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        if (start_i) begin
            a_shift_d = a_i;
            b_shift_d = b_i;
            acc_d     = {WIDTH{1'b0}};
            cnt_d     = {CNT_W{1'b0}};
        end else if (step_i) begin
            // bit k of b selects a<<k; bits shifted past WIDTH are dropped
            if (b_shift_q[0]) begin
                acc_d = acc_q + a_shift_q;
            end else begin
                acc_d = acc_q;
            end
            a_shift_d = a_shift_q << 1;
            b_shift_d = b_shift_q >> 1;
            cnt_d     = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_shift_q <= {WIDTH{1'b0}};
            b_shift_q <= {WIDTH{1'b0}};
            acc_q     <= {WIDTH{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            a_shift_q <= a_shift_d;
            b_shift_q <= b_shift_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: registered execute-stage ALU with valid/ready handshakes.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         alu_exec_if.slave: ALUcontrole/a/b in, resultado/zero/overflow out
// Single-cycle ops complete with latency 1 at one op per cycle. Defining
// ALU_EXEC_MULT_EN adds code 3 as an iterative unsigned multiply (latency
// WIDTH+1, input stalled meanwhile); without it code 3 executes as ADD.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] resultado_q, resultado_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] sum_s, diff_s, op_res_s, mul_res_s;
    logic             op_ovf_s;
    logic             out_free_s, in_ready_s, accept_s;
    logic             is_mul_s, load_alu_s, load_mul_s;

    // The output register can take a new value when empty or draining now.
    assign out_free_s = !out_valid_q || bus.out_ready;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign load_alu_s = accept_s && !is_mul_s;

`ifdef ALU_EXEC_MULT_EN
    alu_state_e       state_q, state_d;
    logic             step_s, last_s, done_s;

    assign in_ready_s = (state_q == IDLE) && out_free_s;
    assign is_mul_s   = (bus.ALUcontrole == ALU_MUL);
    assign load_mul_s = (state_q == DONE);

    mult_iter #(.WIDTH(WIDTH)) u_mult_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (accept_s && is_mul_s),
        .step_i    (step_s),
        .a_i       (bus.a),
        .b_i       (bus.b),
        .last_o    (last_s),
        .done_o    (done_s),
        .product_o (mul_res_s)
    );

    // Sequencing FSM: the final multiply step waits until the output register is free.
    always_comb begin
        state_d = state_q;
        step_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_d = MUL;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                step_s = !last_s || out_free_s;
                if (done_s) begin
                    state_d = DONE;
                end else begin
                    state_d = MUL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`else
    assign in_ready_s = out_free_s;
    assign is_mul_s   = 1'b0;
    assign load_mul_s = 1'b0;
    assign mul_res_s  = {WIDTH{1'b0}};
`endif

    assign sum_s  = bus.a + bus.b;
    assign diff_s = bus.a - bus.b;

    // Single-cycle operation result and signed-overflow flag.
    always_comb begin
        op_res_s = sum_s;
        op_ovf_s = 1'b0;
        case (bus.ALUcontrole)
            ALU_AND: op_res_s = bus.a & bus.b;
            ALU_OR:  op_res_s = bus.a | bus.b;
            ALU_SUB: begin
                op_res_s = diff_s;
                op_ovf_s = (bus.a[MSB] != bus.b[MSB]) && (diff_s[MSB] != bus.a[MSB]);
            end
            ALU_SLT: op_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            ALU_NOR: op_res_s = ~(bus.a | bus.b);
            default: begin
                // ADD, and every unassigned code executes as ADD
                op_res_s = sum_s;
                op_ovf_s = (bus.a[MSB] == bus.b[MSB]) && (sum_s[MSB] != bus.a[MSB]);
            end
        endcase
    end

    // Output register: load a new result, drain on transfer, otherwise hold.
    always_comb begin
        resultado_d = resultado_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        if (load_alu_s) begin
            resultado_d = op_res_s;
            zero_d      = (op_res_s == {WIDTH{1'b0}});
            overflow_d  = op_ovf_s;
            out_valid_d = 1'b1;
        end else if (load_mul_s) begin
            resultado_d = mul_res_s;
            zero_d      = (mul_res_s == {WIDTH{1'b0}});
            overflow_d  = 1'b0;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resultado_q <= {WIDTH{1'b0}};
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            resultado_q <= resultado_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.resultado = resultado_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: self-checking bench for alu_exec (WIDTH=32). Expected values
// come from a behavioural model using plain integer arithmetic. The multiply
// section is compiled only when ALU_EXEC_MULT_EN is defined.
module tb_alu_exec;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    alu_exec_if #(.WIDTH(W)) bus ();

    alu_exec #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: operation semantics written as plain integer arithmetic.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] res, output logic ovf);
        longint sa, sb, s;
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = 1'b0;
        case (op)
            4'd0:  res = a & b;
            4'd1:  res = a | b;
            4'd6:  begin
                s   = sa - sb;
                res = a - b;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7:  res = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: res = ~(a | b);
`ifdef ALU_EXEC_MULT_EN
            4'd3:  res = W'(longint'(a) * longint'(b));
`endif
            default: begin
                s   = sa + sb;
                res = a + b;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid    = 1'b1;
        bus.ALUcontrole = op;
        bus.a           = a;
        bus.b           = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the output register with the model for (op, a, b).
    task automatic check_result(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b);
        logic [W-1:0] er;
        logic         eo;
        model(op, a, b, er, eo);
        check({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, ".res"},   64'(bus.resultado), 64'(er));
        check({tag, ".zero"},  64'(bus.zero),      64'(er == 32'd0));
        check({tag, ".ovf"},   64'(bus.overflow),  64'(eo));
    endtask

    logic [3:0]   d_op   [6] = '{4'd2, 4'd6, 4'd2, 4'd7, 4'd12, 4'd9};
    logic [W-1:0] d_a    [6] = '{32'd7, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd3};
    logic [W-1:0] d_b    [6] = '{32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'd0, 32'd4};
    logic [W-1:0] d_want [6] = '{32'd12, 32'h8000_0000, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd7};

    initial begin
        logic [3:0]   op;
        logic [W-1:0] ra, rb;
        int           n;
        logic         bad;

        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.ALUcontrole = 4'd0;
        bus.a           = 32'd0;
        bus.b           = 32'd0;
        bus.out_ready   = 1'b1;
        repeat (3) tick();
        check("rst.valid", 64'(bus.out_valid), 64'd0);
        check("rst.res",   64'(bus.resultado), 64'd0);
        check("rst.zero",  64'(bus.zero),      64'd0);
        check("rst.ovf",   64'(bus.overflow),  64'd0);
        rst_n = 1'b1;
        tick();

        // Directed operations, one at a time.
        for (int i = 0; i < 6; i++) begin
            drive(d_op[i], d_a[i], d_b[i]);
            #1;
            check("dir.in_ready", 64'(bus.in_ready), 64'd1);
            tick();
            bus.in_valid = 1'b0;
            check_result("dir", d_op[i], d_a[i], d_b[i]);
            check("dir.literal", 64'(bus.resultado), 64'(d_want[i]));
            tick();
        end

        // Random back-to-back operations.
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
`ifdef ALU_EXEC_MULT_EN
            if (op == 4'd3) op = 4'd2;
`endif
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) ra = 32'h8000_0000;
            if (i % 7 == 0) rb = 32'h7FFF_FFFF;
            drive(op, ra, rb);
            tick();
            check_result("rnd", op, ra, rb);
        end
        bus.in_valid = 1'b0;
        tick();
        check("drain.valid", 64'(bus.out_valid), 64'd0);

        // Backpressure: result must hold while stalled, then be replaced on transfer.
        bus.out_ready = 1'b0;
        drive(4'd0, 32'hF0, 32'h3C);
        tick();
        drive(4'd1, 32'hF0, 32'h0F);
        check_result("bp.first", 4'd0, 32'hF0, 32'h3C);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp.in_ready", 64'(bus.in_ready),  64'd0);
            check("bp.hold",     64'(bus.resultado), 64'h30);
            check("bp.valid",    64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp.release_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        check_result("bp.second", 4'd1, 32'hF0, 32'h0F);
        tick();
        check("bp.drain", 64'(bus.out_valid), 64'd0);

        // Streaming: eight ADDs with no bubbles.
        for (int i = 0; i < 8; i++) begin
            drive(4'd2, W'(i), W'(i));
            tick();
            check_result("stream", 4'd2, W'(i), W'(i));
        end
        bus.in_valid = 1'b0;
        tick();

`ifdef ALU_EXEC_MULT_EN
        // Multiply latency and result.
        drive(4'd3, 32'd1234, 32'd5678);
        #1;
        check("mul.in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        n   = 0;
        bad = 1'b0;
        while (!bus.out_valid && n < 100) begin
            if (bus.in_ready) bad = 1'b1;
            tick();
            n++;
        end
        check("mul.latency", 64'(n), 64'(W + 1));
        check("mul.stall", 64'(bad), 64'd0);
        check_result("mul", 4'd3, 32'd1234, 32'd5678);
        check("mul.literal", 64'(bus.resultado), 64'd7006652);
        tick();

        // Random multiply.
        ra = $urandom;
        rb = $urandom;
        drive(4'd3, ra, rb);
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check("mulr.latency", 64'(n), 64'(W + 1));
        check_result("mulr", 4'd3, ra, rb);
        tick();

        // Reset in the middle of a multiply aborts it.
        drive(4'd3, $urandom, $urandom);
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("mrst.valid", 64'(bus.out_valid), 64'd0);
        check("mrst.res",   64'(bus.resultado), 64'd0);
        check("mrst.zero",  64'(bus.zero),      64'd0);
        check("mrst.ovf",   64'(bus.overflow),  64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (bus.out_valid) bad = 1'b1;
        end
        check("mrst.no_late", 64'(bad), 64'd0);
        check("mrst.in_ready", 64'(bus.in_ready), 64'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
